// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN evaluator: operator token codes, FSM states
// and the width helper used to size the operand-stack counter.
package rpn_pkg;

  localparam logic [31:0] OP_ADD = 32'h0000_002B;
  localparam logic [31:0] OP_SUB = 32'h0000_002D;
  localparam logic [31:0] OP_MUL = 32'h0000_002A;
  localparam logic [31:0] OP_EQ  = 32'h0000_003D;

  typedef enum logic [1:0] {
    S_IN   = 2'd0,
    S_EXEC = 2'd1,
    S_RES  = 2'd2
  } state_t;

  // Ceiling log2; the stack counter is clog2(DEPTH+1) bits so it can hold DEPTH.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rpn_evaluator_if.sv
// Token input and result output handshakes between the RPN converter, the
// evaluator and the result consumer.
interface rpn_evaluator_if #(parameter int W = 32);

  logic [W-1:0] I_DAT;
  logic         I_NUM;
  logic         I_STB;
  logic         I_BSY;
  logic         I_ACK;
  logic [W-1:0] O_DAT;
  logic         O_ERR;
  logic         O_STB;
  logic         O_ACK;

  modport master (
    output I_DAT, I_NUM, I_STB, O_ACK,
    input  I_BSY, I_ACK, O_DAT, O_ERR, O_STB
  );

  modport slave (
    input  I_DAT, I_NUM, I_STB, O_ACK,
    output I_BSY, I_ACK, O_DAT, O_ERR, O_STB
  );

endinterface

// File: rtl/rpn_stack.sv
// Operand stack with single push and an atomic pop-two-push-one used to
// retire a binary operator in one cycle.
module rpn_stack
  import rpn_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  localparam int CW   = clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic          pop2_push,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [W-1:0]  next,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          lt2
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] top_idx;
  logic [AW-1:0] next_idx;
  logic          do_push;
  logic          do_pop2;

  assign full     = (count == CW'(DEPTH));
  assign lt2      = (count < CW'(2));
  assign do_push  = push && !full;
  assign do_pop2  = pop2_push && !lt2;
  assign top_idx  = AW'(count - CW'(1));
  assign next_idx = AW'(count - CW'(2));
  assign top      = mem[top_idx];
  assign next     = mem[next_idx];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + CW'(1);
    end else if (do_pop2) begin
      count <= count - CW'(1);
    end
  end

  // The result of a binary op overwrites the slot of its left operand.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[AW'(count)] <= din;
    end else if (do_pop2) begin
      mem[next_idx] <= din;
    end
  end

endmodule

// File: rtl/rpn_evaluator.sv
// Evaluates an RPN token stream on an operand stack and reports one result
// (with error flag) per "="-terminated expression.
module rpn_evaluator
  import rpn_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input logic            CLK,
  input logic            RST,
  rpn_evaluator_if.slave bus
);

  localparam int CW = clog2(DEPTH + 1);

  state_t        state;
  logic          err;
  logic [W-1:0]  op;
  logic          accept;
  logic          is_arith;
  logic          is_eq;
  logic          push;
  logic          pop2_push;
  logic          clear;
  logic [W-1:0]  din;
  logic [W-1:0]  top;
  logic [W-1:0]  next;
  logic [CW-1:0] count;
  logic          full;
  logic          lt2;

  function automatic logic [W-1:0] alu(input logic [W-1:0] opc,
                                       input logic signed [W-1:0] a,
                                       input logic signed [W-1:0] b);
    logic signed [W-1:0] r;
    if (opc == W'(OP_ADD))      r = a + b;
    else if (opc == W'(OP_SUB)) r = a - b;
    else                        r = a * b;
    return r;
  endfunction

  assign accept    = bus.I_STB && !bus.I_BSY && (state == S_IN);
  assign is_arith  = (bus.I_DAT == W'(OP_ADD)) || (bus.I_DAT == W'(OP_SUB)) ||
                     (bus.I_DAT == W'(OP_MUL));
  assign is_eq     = (bus.I_DAT == W'(OP_EQ));
  assign push      = accept && bus.I_NUM && !err && !full;
  assign pop2_push = (state == S_EXEC) && !err && !lt2;
  assign clear     = (state == S_RES) && bus.O_STB && bus.O_ACK;
  assign din       = push ? bus.I_DAT : alu(op, next, top);

  rpn_stack #(.DEPTH(DEPTH), .W(W)) u_stack (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .pop2_push (pop2_push),
    .clear     (clear),
    .din       (din),
    .top       (top),
    .next      (next),
    .count     (count),
    .full      (full),
    .lt2       (lt2)
  );

  always_ff @(posedge CLK) begin
    if (accept && !bus.I_NUM) op <= bus.I_DAT;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IN;
      err       <= 1'b0;
      bus.I_BSY <= 1'b1;
      bus.I_ACK <= 1'b0;
      bus.O_STB <= 1'b0;
      bus.O_ERR <= 1'b0;
      bus.O_DAT <= '0;
    end else begin
      bus.I_ACK <= accept;
      case (state)
        S_IN: begin
          bus.I_BSY <= 1'b0;
          if (accept) begin
            if (bus.I_NUM) begin
              if (!err && full) err <= 1'b1;
            end else if (is_arith) begin
              state     <= S_EXEC;
              bus.I_BSY <= 1'b1;
            end else if (is_eq) begin
              state     <= S_RES;
              bus.I_BSY <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (!err && lt2) err <= 1'b1;
          state     <= S_IN;
          bus.I_BSY <= 1'b0;
        end
        S_RES: begin
          // First cycle latches the result; it is then held until acknowledged.
          if (!bus.O_STB) begin
            bus.O_STB <= 1'b1;
            if (!err && count == CW'(1)) begin
              bus.O_DAT <= top;
              bus.O_ERR <= 1'b0;
            end else begin
              bus.O_DAT <= '0;
              bus.O_ERR <= 1'b1;
            end
          end else if (bus.O_ACK) begin
            bus.O_STB <= 1'b0;
            err       <= 1'b0;
            state     <= S_IN;
            bus.I_BSY <= 1'b0;
          end
        end
        default: begin
          state     <= S_IN;
          bus.I_BSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_evaluator.sv
// Directed and randomized RPN expressions checked against a queue-based
// stack evaluator.
module tb_rpn_evaluator;

  localparam int DEPTH = 16;
  localparam int W     = 32;

  typedef struct {
    logic         num;
    logic [W-1:0] dat;
  } tok_t;

  logic CLK = 1'b0;
  logic RST;
  int   tests = 0;
  int   fails = 0;
  int   ack_cnt = 0;
  tok_t toks[$];

  always #5 CLK = ~CLK;

  rpn_evaluator_if #(.W(W)) bus ();

  rpn_evaluator #(.DEPTH(DEPTH), .W(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always @(negedge CLK) if (bus.I_ACK === 1'b1) ack_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic num(input logic [W-1:0] v);
    tok_t t;
    t.num = 1'b1; t.dat = v;
    toks.push_back(t);
  endtask

  task automatic opr(input logic [W-1:0] c);
    tok_t t;
    t.num = 1'b0; t.dat = c;
    toks.push_back(t);
  endtask

  // Reference: plain stack evaluation of the token list up to "=".
  task automatic model(output logic e, output logic [W-1:0] v);
    logic [W-1:0] st[$];
    logic [W-1:0] a, b, d;
    e = 1'b0;
    foreach (toks[i]) begin
      d = toks[i].dat;
      if (toks[i].num) begin
        if (!e) begin
          if (st.size() == DEPTH) e = 1'b1;
          else st.push_back(d);
        end
      end else if (d == 32'h3D) begin
        break;
      end else if (d == 32'h2B || d == 32'h2D || d == 32'h2A) begin
        if (!e) begin
          if (st.size() < 2) e = 1'b1;
          else begin
            b = st.pop_back();
            a = st.pop_back();
            st.push_back(d == 32'h2B ? a + b : d == 32'h2D ? a - b : a * b);
          end
        end
      end else begin
        e = 1'b1;
      end
    end
    if (!e && st.size() == 1) v = st[0];
    else begin
      e = 1'b1;
      v = '0;
    end
  endtask

  task automatic send(input tok_t t);
    int n;
    @(negedge CLK);
    bus.I_NUM = t.num;
    bus.I_DAT = t.dat;
    bus.I_STB = 1'b1;
    n = 0;
    while (bus.I_BSY !== 1'b0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n == 50) begin
      check("send_timeout", 32'd0, 32'd1);
      bus.I_STB = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    bus.I_STB = 1'b0;
    check("i_ack", {31'd0, bus.I_ACK}, 32'd1);
  endtask

  task automatic do_ack();
    @(negedge CLK);
    bus.O_ACK = 1'b1;
    @(posedge CLK);
    #1;
    bus.O_ACK = 1'b0;
    check("o_stb_after_ack", {31'd0, bus.O_STB}, 32'd0);
    check("i_bsy_after_ack", {31'd0, bus.I_BSY}, 32'd0);
  endtask

  task automatic run_expr(input string tag, input bit hold);
    logic         e;
    logic [W-1:0] v;
    int           a0;
    model(e, v);
    a0 = ack_cnt;
    foreach (toks[i]) send(toks[i]);
    @(posedge CLK);
    #1;
    check({tag, "_stb"}, {31'd0, bus.O_STB}, 32'd1);
    check({tag, "_dat"}, bus.O_DAT, v);
    check({tag, "_err"}, {31'd0, bus.O_ERR}, {31'd0, e});
    check({tag, "_acks"}, ack_cnt - a0, toks.size());
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge CLK);
        bus.I_NUM = 1'b1;
        bus.I_DAT = 32'd99;
        bus.I_STB = 1'b1;
        @(posedge CLK);
        #1;
        check("hold_stb", {31'd0, bus.O_STB}, 32'd1);
        check("hold_dat", bus.O_DAT, v);
        check("hold_bsy", {31'd0, bus.I_BSY}, 32'd1);
        check("hold_noack", {31'd0, bus.I_ACK}, 32'd0);
      end
      bus.I_STB = 1'b0;
    end
    do_ack();
    toks.delete();
  endtask

  task automatic gen_random();
    int d, len, r;
    toks.delete();
    d = 0;
    len = $urandom_range(1, 14);
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(0, 19);
      if (r == 19) opr(32'h2F);
      else if (r == 18) opr(32'h2D);
      else if (r < 10 || d < 2) begin
        num(($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20)));
        d++;
      end else begin
        r = $urandom_range(0, 2);
        opr(r == 0 ? 32'h2B : r == 1 ? 32'h2D : 32'h2A);
        d--;
      end
    end
    while (d > 1) begin
      opr(($urandom_range(0, 1) == 1) ? 32'h2B : 32'h2A);
      d--;
    end
    opr(32'h3D);
  endtask

  initial begin
    RST       = 1'b1;
    bus.I_DAT = '0;
    bus.I_NUM = 1'b0;
    bus.I_STB = 1'b0;
    bus.O_ACK = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_bsy", {31'd0, bus.I_BSY}, 32'd1);
    check("rst_ack", {31'd0, bus.I_ACK}, 32'd0);
    check("rst_stb", {31'd0, bus.O_STB}, 32'd0);
    check("rst_err", {31'd0, bus.O_ERR}, 32'd0);
    check("rst_dat", bus.O_DAT, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("rel_bsy", {31'd0, bus.I_BSY}, 32'd0);

    num(3); num(4); opr(32'h2B); num(2); opr(32'h2A); opr(32'h3D);
    run_expr("mix14", 1'b0);
    num(10); num(3); opr(32'h2D); opr(32'h3D);
    run_expr("sub7", 1'b0);
    num(32'h7FFF_FFFF); num(1); opr(32'h2B); opr(32'h3D);
    run_expr("addwrap", 1'b0);
    num(32'h0001_0000); num(32'h0001_0000); opr(32'h2A); opr(32'h3D);
    run_expr("mulwrap", 1'b0);
    num(5); opr(32'h2B); opr(32'h3D);
    run_expr("underflow", 1'b0);
    opr(32'h3D);
    run_expr("empty", 1'b0);
    num(1); num(2); opr(32'h3D);
    run_expr("leftover", 1'b0);
    num(2); num(2); opr(32'h2B); opr(32'h3D);
    run_expr("errclr", 1'b0);
    for (int i = 0; i <= DEPTH; i++) num(32'(i));
    opr(32'h3D);
    run_expr("overflow", 1'b0);
    num(6); num(2); opr(32'h2F); opr(32'h3D);
    run_expr("badop", 1'b0);
    num(8); num(9); opr(32'h2B); opr(32'h3D);
    run_expr("hold", 1'b1);

    num(3); num(4); opr(32'h2B);
    foreach (toks[i]) send(toks[i]);
    toks.delete();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("arst_bsy", {31'd0, bus.I_BSY}, 32'd1);
    check("arst_ack", {31'd0, bus.I_ACK}, 32'd0);
    check("arst_stb", {31'd0, bus.O_STB}, 32'd0);
    check("arst_err", {31'd0, bus.O_ERR}, 32'd0);
    check("arst_dat", bus.O_DAT, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    num(1); num(1); opr(32'h2B); opr(32'h3D);
    run_expr("after_rst", 1'b0);

    for (int n = 0; n < 40; n++) begin
      gen_random();
      run_expr("rand", 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
